// File: rtl/render_pkg.sv
// render_pkg: shared framebuffer geometry and the write-record type.
//   H_RES, V_RES : visible raster size in pixels
//   ADDRW        : linear framebuffer address width (2**ADDRW >= H_RES*V_RES)
//   COLRW        : colour width
//   fb_wr_t      : one buffered framebuffer write {addr, col}
package render_pkg;

    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int ADDRW = 19;
    localparam int COLRW = 4;

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [COLRW-1:0] col;
    } fb_wr_t;

endpackage

// File: rtl/fb_fifo.sv
// fb_fifo: synchronous first-word-fall-through FIFO of fb_wr_t records.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : write a record; caller guarantees !full || pop
//   pop        : drop the head; caller guarantees !empty
//   rdata      : current head, valid whenever !empty
//   empty/full : occupancy flags
//   count      : number of stored records, 0..DEPTH
module fb_fifo
    import render_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  fb_wr_t      wdata,
    input  logic        pop,
    output fb_wr_t      rdata,
    output logic        empty,
    output logic        full,
    output logic [AW:0] count
);

    fb_wr_t         mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; stale contents are never visible while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/span_fb_writer.sv
// span_fb_writer: turns the line scanner's pixel stream into framebuffer writes.
//   clk, rst_n          : clock, asynchronous active-low reset
//   drawing, x, y       : scanner pixel valid and coordinates
//   colour              : fill colour sampled with each pixel
//   scan_done           : one-cycle end-of-scan pulse
//   oe                  : output enable back to the scanner (0 = stall)
//   fb_we/fb_addr/fb_data, fb_ready : valid/ready write port, FWFT head
//   busy                : a frame is in flight
//   frame_done          : one-cycle pulse once the scan ended and all writes drained
//   overflow            : sticky, a pixel was dropped on a full FIFO
// ADDRW/COLRW overrides must match render_pkg, since fb_wr_t is sized there.
module span_fb_writer
    import render_pkg::fb_wr_t;
#(
    parameter int CORDW = 10,
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int COLRW = 4,
    parameter int ADDRW = 19,
    parameter int DEPTH = 8,
    parameter int SKID  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             drawing,
    input  logic [CORDW-1:0] x,
    input  logic [CORDW-1:0] y,
    input  logic [COLRW-1:0] colour,
    input  logic             scan_done,
    output logic             oe,
    output logic             fb_we,
    output logic [ADDRW-1:0] fb_addr,
    output logic [COLRW-1:0] fb_data,
    input  logic             fb_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          s1_v;
    fb_wr_t        s1_wr;
    logic          accept;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    fb_wr_t        head;
    logic          done_pend;
    logic          fire;

    assign accept = drawing && (32'(x) < 32'(H_RES)) && (32'(y) < 32'(V_RES));

    // Stage 1: clip and linearise. Product is formed at 32 bits, then truncated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_wr <= '0;
        end else begin
            s1_v <= accept;
            if (accept) begin
                s1_wr.addr <= ADDRW'(32'(y) * 32'(H_RES) + 32'(x));
                s1_wr.col  <= colour;
            end
        end
    end

    // A pop frees a slot this same edge, so a full FIFO still accepts then.
    assign pop  = fb_we && fb_ready;
    assign push = s1_v && (!full || pop);

    fb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (s1_wr),
        .pop   (pop),
        .rdata (head),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign fb_we   = !empty;
    assign fb_addr = head.addr;
    assign fb_data = head.col;

    // Reserve SKID slots for pixels the scanner emits before it sees oe fall.
    assign oe = (32'(count) + 32'(s1_v)) <= 32'(DEPTH - 1 - SKID);

    // Stage-1 must be empty too, otherwise a pixel could still be on its way in.
    assign fire = done_pend && !s1_v && empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            done_pend  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (s1_v && full && !pop) overflow <= 1'b1;
            frame_done <= fire;
            // A new scan_done or pixel wins over a same-edge completion.
            if (scan_done)   done_pend <= 1'b1;
            else if (fire)   done_pend <= 1'b0;
            if (accept || scan_done) busy <= 1'b1;
            else if (fire)           busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_span_fb_writer.sv
module tb_span_fb_writer;
    import render_pkg::*;

    localparam int DEPTH = 8;
    localparam int SKID  = 2;
    localparam int HR    = 640;
    localparam int VR    = 480;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        drawing = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [3:0]  colour = '0;
    logic        scan_done = 1'b0;
    logic        fb_ready = 1'b0;
    logic        oe, fb_we, busy, frame_done, overflow;
    logic [18:0] fb_addr;
    logic [3:0]  fb_data;

    int tests = 0;
    int failed = 0;

    // Reference model: pending pixel, buffered queue, expected write order.
    fb_wr_t got[$];
    fb_wr_t exp_w[$];
    fb_wr_t m_q[$];
    logic   m_v = 1'b0;
    fb_wr_t m_w;
    logic   m_ovf = 1'b0;

    always #5 clk = ~clk;

    span_fb_writer dut (
        .clk(clk), .rst_n(rst_n), .drawing(drawing), .x(x), .y(y), .colour(colour),
        .scan_done(scan_done), .oe(oe), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_ready(fb_ready), .busy(busy), .frame_done(frame_done), .overflow(overflow)
    );

    // Inputs only change just after posedge, so negedge sees a settled handshake.
    always @(negedge clk)
        if (rst_n && fb_we && fb_ready) got.push_back(fb_wr_t'({fb_addr, fb_data}));

    function automatic logic model_oe();
        return (m_q.size() + (m_v ? 1 : 0)) <= DEPTH - 1 - SKID;
    endfunction

    task automatic clear_model();
        m_q.delete(); exp_w.delete(); got.delete();
        m_v = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; drawing = 1'b0; scan_done = 1'b0; fb_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        clear_model();
    endtask

    // One clock: apply inputs, let the edge happen, advance the model.
    task automatic drive(input logic d, input int xi, input int yi, input logic [3:0] c,
                         input logic r, input logic sd);
        drawing = d; x = 10'(xi); y = 10'(yi); colour = c; fb_ready = r; scan_done = sd;
        @(posedge clk);
        if (m_q.size() > 0 && r) exp_w.push_back(m_q.pop_front());
        if (m_v) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_w);
            else m_ovf = 1'b1;
        end
        m_v = d && (xi < HR) && (yi < VR);
        m_w = fb_wr_t'({19'(yi * HR + xi), c});
        #1;
        scan_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests++; if (oe !== 1'b1) begin failed++; $display("FAIL reset_oe got=%b exp=1", oe); end
        tests++; if (fb_we !== 1'b0) begin failed++; $display("FAIL reset_fb_we got=%b exp=0", fb_we); end
        tests++; if ({busy, frame_done, overflow} !== 3'b000)
            begin failed++; $display("FAIL reset_flags got=%b exp=000", {busy, frame_done, overflow}); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        drive(1, 5, 2, 4'd3, 1, 0);
        tests++; if (fb_we !== 1'b0) begin failed++; $display("FAIL single_early got=%b exp=0", fb_we); end
        drive(0, 0, 0, 0, 1, 0);
        tests++; if (fb_we !== 1'b1) begin failed++; $display("FAIL single_we got=%b exp=1", fb_we); end
        tests++; if (fb_addr !== 19'd1285 || fb_data !== 4'd3)
            begin failed++; $display("FAIL single_data got=%0d/%0d exp=1285/3", fb_addr, fb_data); end
        drive(0, 0, 0, 0, 1, 0);
        tests++; if (fb_we !== 1'b0) begin failed++; $display("FAIL single_after got=%b exp=0", fb_we); end
        repeat (4) drive(0, 0, 0, 0, 1, 0);
        tests++; if (got.size() !== 1) begin failed++; $display("FAIL single_count got=%0d exp=1", got.size()); end
    endtask

    task automatic test_row();
        int oe_bad = 0;
        int bad = 0;
        do_reset();
        for (int xi = 0; xi < HR; xi++) begin
            if (oe !== 1'b1) oe_bad++;
            drive(1, xi, 479, 4'(xi), 1, 0);
        end
        repeat (5) drive(0, 0, 0, 0, 1, 0);
        tests++; if (oe_bad !== 0) begin failed++; $display("FAIL row_oe low_cycles=%0d exp=0", oe_bad); end
        tests++; if (got.size() !== 640) begin failed++; $display("FAIL row_count got=%0d exp=640", got.size()); end
        if (got.size() == 640) begin
            tests++; if (got[0].addr !== 19'd306560 || got[639].addr !== 19'd307199) begin
                failed++; $display("FAIL row_ends got=%0d..%0d exp=306560..307199", got[0].addr, got[639].addr);
            end
        end
        foreach (exp_w[i]) if (i >= got.size() || got[i] !== exp_w[i]) bad++;
        tests++; if (bad !== 0) begin failed++; $display("FAIL row_order bad=%0d exp=0", bad); end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        int oe_bad = 0;
        int bad = 0;
        logic e;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            e = model_oe();
            if (oe !== e) oe_bad++;
            drive(e, accepted, 10, 4'($urandom), 0, 0);
            if (e) accepted++;
        end
        tests++; if (oe_bad !== 0) begin failed++; $display("FAIL bp_oe bad=%0d exp=0", oe_bad); end
        tests++; if (oe !== 1'b0) begin failed++; $display("FAIL bp_stalled got=%b exp=0", oe); end
        tests++; if (accepted !== DEPTH - SKID) begin failed++; $display("FAIL bp_accepted got=%0d exp=%0d", accepted, DEPTH - SKID); end
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL bp_overflow got=%b exp=0", overflow); end
        repeat (12) drive(0, 0, 0, 0, 1, 0);
        tests++; if (got.size() !== DEPTH - SKID) begin failed++; $display("FAIL bp_drain got=%0d exp=%0d", got.size(), DEPTH - SKID); end
        foreach (exp_w[i]) if (i >= got.size() || got[i] !== exp_w[i]) bad++;
        tests++; if (bad !== 0) begin failed++; $display("FAIL bp_order bad=%0d exp=0", bad); end
    endtask

    task automatic test_overflow();
        int bad = 0;
        do_reset();
        for (int k = 0; k < 9; k++) drive(1, k, 20, 4'(k), 0, 0);
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL ovf_early got=%b exp=0", overflow); end
        drive(0, 0, 0, 0, 0, 0);
        tests++; if (overflow !== 1'b1 || m_ovf !== 1'b1) begin failed++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        repeat (12) drive(0, 0, 0, 0, 1, 0);
        tests++; if (got.size() !== DEPTH) begin failed++; $display("FAIL ovf_count got=%0d exp=%0d", got.size(), DEPTH); end
        if (got.size() == DEPTH) begin
            tests++; if (got[DEPTH-1].addr !== 19'(20 * 640 + 7))
                begin failed++; $display("FAIL ovf_last got=%0d exp=%0d", got[DEPTH-1].addr, 20 * 640 + 7); end
        end
        foreach (exp_w[i]) if (i >= got.size() || got[i] !== exp_w[i]) bad++;
        tests++; if (bad !== 0) begin failed++; $display("FAIL ovf_order bad=%0d exp=0", bad); end
        tests++; if (overflow !== 1'b1) begin failed++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_clip_done();
        int we_seen = 0;
        int cx[4] = '{640, 0, 1023, 639};
        int cy[4] = '{0, 480, 1023, 480};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, cx[k], cy[k], 4'hF, 1, 0);
            if (fb_we) we_seen++;
        end
        drive(0, 0, 0, 0, 1, 0);
        if (fb_we) we_seen++;
        tests++; if (we_seen !== 0) begin failed++; $display("FAIL clip_we got=%0d exp=0", we_seen); end
        tests++; if (overflow !== 1'b0 || busy !== 1'b0)
            begin failed++; $display("FAIL clip_flags got=%b%b exp=00", overflow, busy); end
        drive(0, 0, 0, 0, 1, 1);
        tests++; if (frame_done !== 1'b0 || busy !== 1'b1)
            begin failed++; $display("FAIL done_pend got=%b%b exp=01", frame_done, busy); end
        drive(0, 0, 0, 0, 1, 0);
        tests++; if (frame_done !== 1'b1 || busy !== 1'b0)
            begin failed++; $display("FAIL done_pulse got=%b%b exp=10", frame_done, busy); end
        drive(0, 0, 0, 0, 1, 0);
        tests++; if (frame_done !== 1'b0) begin failed++; $display("FAIL done_width got=%b exp=0", frame_done); end
    endtask

    task automatic test_reset_mid();
        int we_seen = 0;
        do_reset();
        for (int k = 0; k < 5; k++) drive(1, k, 3, 4'(k), 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        tests++; if (fb_we !== 1'b1 || busy !== 1'b1)
            begin failed++; $display("FAIL mid_loaded got=%b%b exp=11", fb_we, busy); end
        rst_n = 1'b0;
        #1;
        tests++; if (fb_we !== 1'b0 || busy !== 1'b0 || oe !== 1'b1)
            begin failed++; $display("FAIL mid_async got=%b%b%b exp=001", fb_we, busy, oe); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_model();
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            if (fb_we) we_seen++;
        end
        tests++; if (we_seen !== 0 || got.size() !== 0)
            begin failed++; $display("FAIL mid_stale got=%0d/%0d exp=0/0", we_seen, got.size()); end
    endtask

    task automatic test_random();
        int oe_bad = 0;
        int bad = 0;
        int fd_early = 0;
        int fd_cnt = 0;
        int fd_we = 0;
        logic d;
        logic r;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (oe !== model_oe()) oe_bad++;
            d = ($urandom_range(0, 3) != 0) && (model_oe() || $urandom_range(0, 7) == 0);
            r = $urandom_range(0, 2) != 0;
            drive(d, $urandom_range(0, 700), $urandom_range(0, 520), 4'($urandom), r, 0);
            if (frame_done) fd_early++;
        end
        drive(0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 40; k++) begin
            if (frame_done) begin fd_cnt++; if (fb_we) fd_we++; end
            drive(0, 0, 0, 0, 1, 0);
        end
        tests++; if (oe_bad !== 0) begin failed++; $display("FAIL rnd_oe bad=%0d exp=0", oe_bad); end
        tests++; if (fd_early !== 0) begin failed++; $display("FAIL rnd_early_done got=%0d exp=0", fd_early); end
        tests++; if (fd_cnt !== 1 || fd_we !== 0)
            begin failed++; $display("FAIL rnd_done pulses=%0d we_at_done=%0d exp=1/0", fd_cnt, fd_we); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rnd_busy got=%b exp=0", busy); end
        tests++; if (overflow !== m_ovf) begin failed++; $display("FAIL rnd_overflow got=%b exp=%b", overflow, m_ovf); end
        tests++; if (got.size() !== exp_w.size())
            begin failed++; $display("FAIL rnd_count got=%0d exp=%0d", got.size(), exp_w.size()); end
        foreach (exp_w[i]) if (i >= got.size() || got[i] !== exp_w[i]) bad++;
        tests++; if (bad !== 0) begin failed++; $display("FAIL rnd_order bad=%0d exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_row();
        test_backpressure();
        test_overflow();
        test_clip_done();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
